rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
- Sequencer that sits directly upstream of the 256x8 sky130 ROM macro. It drives the ROM's chip-select and address, and consumes its registered data output.
- Accepts a burst command (start address, length) and emits the read bytes as a valid/ready byte stream with a last flag.
- Absorbs the ROM read latency with a small output FIFO, so downstream backpressure never loses data.
- Lets tile-level logic stream lookup tables or patterns out of ROM without per-byte address handling.

Parameters:
- ADDR_W, 8, ROM address width; the ROM holds 2^ADDR_W words.
- DATA_W, 8, ROM word width.
- ROM_LATENCY, 1, clk cycles from rom_cs/rom_addr sampled to rom_dout valid; legal range 1..3.
- FIFO_DEPTH, 2, output FIFO entries; must be >= 1. Full throughput requires FIFO_DEPTH >= ROM_LATENCY+1.

Ports:
- clk  in  1  single clock; also clocks the ROM macro.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_addr  in  ADDR_W  first ROM address of the burst.
- cmd_len  in  ADDR_W  burst length minus one; 0 means 1 byte, 255 means 256 bytes.
- busy  out  1  high from command accept until the last byte is handed off.
- rom_cs  out  1  ROM chip select; one read per cycle in which it is high.
- rom_addr  out  ADDR_W  ROM read address.
- rom_dout  in  DATA_W  ROM data, valid ROM_LATENCY cycles after the issuing cycle.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  DATA_W  stream byte.
- out_last  out  1  marks the final byte of the burst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs: cmd_ready=1, busy=0, rom_cs=0, rom_addr=0, out_valid=0, out_data=0, out_last=0.
  - FIFO is emptied and all in-flight reads are discarded (latency valid shift register cleared).
  - Reset mid-burst aborts the burst; no further bytes appear.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr and remaining=cmd_len, go to ISSUE.
  - ISSUE: issue reads; after the read with remaining==0 is issued, go to DRAIN.
  - DRAIN: wait until in-flight count is 0 and FIFO is empty, then go to IDLE.
  - busy = (state != IDLE).
- Issue rule: rom_cs=1 in a cycle only if ISSUE and (inflight + fifo_count) < FIFO_DEPTH. This credit check counts an entry popped in the same cycle, so a full FIFO with out_ready=1 may still issue.
  - rom_addr = current address.
  - Each issue increments the address modulo 2^ADDR_W (255+1 wraps to 0) and decrements remaining.
  - rom_addr holds its last value while rom_cs=0.
- Latency tracking: a ROM_LATENCY-deep shift register of {valid, last} tags follows each issue. When a tag with valid=1 emerges, rom_dout and the last tag are pushed into the FIFO in that cycle. The credit rule guarantees the push never overflows.
- Output: out_valid = FIFO non-empty; out_data/out_last come from the FIFO head. A pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle are allowed: count is unchanged, order is preserved.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held high and default parameters, one byte per cycle. The first out_valid occurs ROM_LATENCY+1 cycles after the command-accept edge (1 cycle to reach ISSUE, ROM_LATENCY to the FIFO push).
- Commands: a new command is accepted only in IDLE; back-to-back bursts therefore have at least one idle cycle of separation. cmd_valid outside IDLE is ignored (not queued).
- Length 256 (cmd_len=255) from any start address produces exactly 256 bytes, covering every address once with wrap.

Decomposition:
- Shared package rom_stream_pkg holds:
  - localparams for default ADDR_W/DATA_W/ROM_LATENCY;
  - the state enum (IDLE, ISSUE, DRAIN);
  - a packed fifo entry type {last, data}.
- One sub-module: rom_stream_fifo, a synchronous FIFO of FIFO_DEPTH entries with push/pop/count, first-word-fall-through, and synchronous active-high reset.
- The top level instantiates the FSM, the latency shift register and rom_stream_fifo. The ROM macro is instantiated by the parent, not inside this block.

Test Plan:
- Single byte, cmd_addr=8'h10, cmd_len=0, out_ready=1 -> one beat, ROM[0x10] with out_last=1. rom_cs high exactly one cycle. busy falls the cycle after the handoff.
- Burst cmd_addr=8'h00, cmd_len=7, out_ready=1 -> ROM[0..7] on 8 consecutive cycles, out_last only on the 8th. First out_valid 2 cycles after accept.
- Wrap: cmd_addr=8'hFE, cmd_len=3 -> addresses FE, FF, 00, 01 in order. cmd_len=255 from 8'h80 -> 256 beats, each address exactly once.
- Backpressure: cmd_len=15 with out_ready toggling randomly and held low for 10 cycles mid-burst -> no loss or duplication, data stable while stalled, rom_cs low while credits are exhausted.
- Reset mid-burst: assert rst for 1 cycle after 3 of 10 bytes -> out_valid=0 next cycle, state IDLE, no stale bytes. A new command then returns correct data.
- Command while busy: pulse cmd_valid with cmd_addr=8'h40 during a burst -> ignored, cmd_ready=0, original burst unaffected.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and defaults for the ROM stream reader.
// Holds the FSM state enum, the FIFO entry layout and default widths.
package rom_stream_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ROM_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rom_stream_fifo.sv
// First-word-fall-through FIFO for the ROM stream output.
// Ports: push/wdata in, pop/rdata out (head), count of held entries.
module rom_stream_fifo
  import rom_stream_pkg::*;
#(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  parameter type T     = fifo_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  output T                 rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // A full FIFO may still take a push when it pops in the same cycle.
    do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_d    = do_pop ? nxt(rd_q) : rd_q;
    wr_d    = do_push ? nxt(wr_q) : wr_q;
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a registered-output ROM macro.
// Ports: cmd (addr,len) in; rom_cs/rom_addr/rom_dout; out byte stream.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              busy,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      rem_q, rem_d;
  logic [ROM_LATENCY-1:0] tv_q, tv_d;
  logic [ROM_LATENCY-1:0] tl_q, tl_d;

  entry_t           push_e;
  entry_t           head_e;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fcnt;
  int               inflight;
  int               used;
  logic             credit;

  always_comb begin
    inflight = $countones(tv_q);
    pop      = out_valid && out_ready;
    // Reads in flight plus stored bytes, less the one leaving now.
    used     = inflight + int'(fcnt) - int'(pop);
    credit   = used < FIFO_DEPTH;

    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rom_cs    = 1'b0;
    cmd_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          rom_cs = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == 0 && fcnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tv_d[0] = rom_cs;
    tl_d[0] = rom_cs && (rem_q == '0);
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tv_d[i] = tv_q[i-1];
      tl_d[i] = tl_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tv_q    <= '0;
      tl_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
    end
  end

  assign push        = tv_q[ROM_LATENCY-1];
  assign push_e.last = tl_q[ROM_LATENCY-1];
  assign push_e.data = rom_dout;

  rom_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_e),
    .pop   (pop),
    .rdata (head_e),
    .count (fcnt)
  );

  assign out_valid = (fcnt != '0);
  assign out_data  = out_valid ? head_e.data : '0;
  assign out_last  = out_valid && head_e.last;
  assign rom_addr  = addr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader with a 1-cycle ROM model.
// Expected bytes/addresses come from a burst-level queue model.
module tb_rom_stream_reader;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       busy;
  logic       rom_cs;
  logic [7:0] rom_addr;
  logic [7:0] rom_dout = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;

  logic [7:0] rom [256];
  logic [8:0] exp_q [$];
  logic [7:0] adr_q [$];
  int         issued = 0;
  int         popped = 0;
  int         cs_total = 0;
  int         rdy_mode = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  always #5 clk = ~clk;

  rom_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always @(posedge clk) begin
    if (rom_cs) rom_dout <= rom[rom_addr];
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_beat", {out_last, out_data}, prev_beat);
    end
    if (rom_cs) begin
      issued++;
      cs_total++;
      if (adr_q.size() == 0) check("extra_cs", 32'(rom_cs), 0);
      else check("rom_addr", rom_addr, adr_q.pop_front());
    end
    if (out_valid && out_ready) begin
      popped++;
      if (exp_q.size() == 0) check("extra_beat", 32'(out_valid), 0);
      else check("beat", {out_last, out_data}, exp_q.pop_front());
    end
    if (rom_cs) check("credit", 32'(issued - popped <= DEPTH), 1);
    prev_stall = out_valid && !out_ready;
    prev_beat  = {out_last, out_data};
    if (rst) begin
      exp_q.delete();
      adr_q.delete();
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
    int t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      adr_q.push_back(a + 8'(i));
      exp_q.push_back({i == int'(l), rom[a + 8'(i)]});
    end
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_rom_cs"}, 32'(rom_cs), 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
  endtask

  initial begin
    int cs0;
    int t;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // single byte from 0x10
    cs0 = cs_total;
    send_cmd(8'h10, 8'd0);
    @(negedge clk); check("t1_lat1", 32'(out_valid), 0);
    @(negedge clk); check("t1_lat2", 32'(out_valid), 0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", out_data, 8'h4A);
    check("t1_last", 32'(out_last), 1);
    @(negedge clk);
    @(negedge clk);
    check("t1_busy_low", 32'(busy), 0);
    wait_idle(20);
    check("t1_cs_count", cs_total - cs0, 1);

    // 8-byte burst from 0
    send_cmd(8'h00, 8'd7);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(out_valid), 1);
      check("t2_last", 32'(out_last), 32'(i == 7));
      if (i == 0) check("t2_first", out_data, 8'h5A);
      if (i == 7) check("t2_eighth", out_data, 8'h5D);
    end
    wait_idle(20);

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

    // wrap cases
    send_cmd(8'hFE, 8'd3);
    wait_idle(50);
    cs0 = cs_total;
    send_cmd(8'h80, 8'd255);
    wait_idle(600);
    check("t3_cs_count", cs_total - cs0, 256);

    // backpressure with a 10-cycle hard stall
    rdy_mode = 1;
    send_cmd(8'h33, 8'd15);
    repeat (6) @(negedge clk);
    rdy_mode = 2;
    repeat (11) @(negedge clk);
    check("bp_cs_stalled", 32'(rom_cs), 0);
    check("bp_valid_held", 32'(out_valid), 1);
    rdy_mode = 1;
    wait_idle(300);

    // reset mid-burst after 3 of 10 bytes
    rdy_mode = 0;
    send_cmd(8'h20, 8'd9);
    t = 0;
    while (popped < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_reached", 32'(popped >= 3), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_mid");
    repeat (5) @(negedge clk);
    send_cmd(8'h20, 8'd9);
    wait_idle(50);

    // command pulse while busy is ignored
    rdy_mode = 1;
    cs0 = cs_total;
    send_cmd(8'h50, 8'd15);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd5;
    @(negedge clk);
    check("busy_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle(200);
    check("busy_cs_count", cs_total - cs0, 16);

    // random bursts
    for (int k = 0; k < 20; k++) begin
      rdy_mode = int'($urandom % 2);
      send_cmd(8'($urandom), 8'($urandom % 48));
      wait_idle(500);
    end

    rdy_mode = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
